// File: rtl/div_preset_ctrl_pkg.sv
// Shared types and helpers for the preset-table frequency divider controller.
package div_ctrl_pkg;

    localparam int DIV_W = 32;

    typedef logic [1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam idx_t IDX_MIN = 2'd0;
    localparam idx_t IDX_MAX = 2'd3;

    function automatic logic [DIV_W-1:0] preset_for(
        input idx_t             idx,
        input logic [DIV_W-1:0] p0,
        input logic [DIV_W-1:0] p1,
        input logic [DIV_W-1:0] p2,
        input logic [DIV_W-1:0] p3
    );
        logic [DIV_W-1:0] r;
        case (idx)
            2'd0:    r = p0;
            2'd1:    r = p1;
            2'd2:    r = p2;
            2'd3:    r = p3;
            default: r = p0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/div_preset_ctrl_prog_fdiv.sv
// Programmable divider core: counter 1..divn, half compare, registered fout and tick.
// wrap flags the last cycle of a period so the controller can commit a new ratio there.
module prog_fdiv
    import div_ctrl_pkg::*;
(
    input  logic             fin,
    input  logic             rst_n,
    input  logic             en,
    input  logic             reload,
    input  logic [DIV_W-1:0] divn,
    output logic             fout,
    output logic             tick,
    output logic             wrap
);

    logic [DIV_W-1:0] count_r;
    logic [DIV_W-1:0] count_s;
    logic [DIV_W-1:0] half_s;
    logic             fout_s;
    logic             tick_s;

    assign half_s = divn >> 1;
    assign wrap   = en && (count_r == divn);

    // Next counter value and output levels; a disabled divider parks at count 1 with outputs low.
    always_comb begin
        count_s = 32'd1;
        fout_s  = 1'b0;
        tick_s  = 1'b0;
        if (en) begin
            if (wrap || reload) begin
                count_s = 32'd1;
            end else begin
                count_s = count_r + 32'd1;
            end
            fout_s = (count_r > half_s);
            tick_s = wrap;
        end else begin
            count_s = 32'd1;
            fout_s  = 1'b0;
            tick_s  = 1'b0;
        end
    end

    // Counter and output registers.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 32'd1;
            fout    <= 1'b0;
            tick    <= 1'b0;
        end else begin
            count_r <= count_s;
            fout    <= fout_s;
            tick    <= tick_s;
        end
    end

endmodule

// File: rtl/div_preset_ctrl.sv
// Preset-stepping divider controller: button sync/edge detect, target index, commit FSM.
// Optional button debounce is compiled in with DIV_PRESET_CTRL_DEBOUNCE_EN.
module div_preset_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned PRESET0    = 32'd50000000,
    parameter int unsigned PRESET1    = 32'd5000000,
    parameter int unsigned PRESET2    = 32'd50000,
    parameter int unsigned PRESET3    = 32'd2000,
    parameter int unsigned DEB_CYCLES = 32'd1000000
)(
    input  logic       fin,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       run,
    output logic       fout,
    output logic       tick,
    output logic [1:0] sel,
    output logic       pending
);

    // bit 0 = up, bit 1 = down
    logic [1:0]       btn_meta_r;
    logic [1:0]       btn_sync_r;
    logic [1:0]       btn_lvl_s;
    logic [1:0]       btn_prev_r;
    logic [1:0]       rise_s;
    idx_t             target_r;
    idx_t             target_s;
    idx_t             sel_r;
    idx_t             sel_s;
    state_t           state_r;
    state_t           state_s;
    logic             pending_r;
    logic             reload_s;
    logic             en_s;
    logic             wrap_s;
    logic [DIV_W-1:0] divn_s;

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_r <= 2'b00;
            btn_sync_r <= 2'b00;
        end else begin
            btn_meta_r <= {btn_dn, btn_up};
            btn_sync_r <= btn_meta_r;
        end
    end

`ifdef DIV_PRESET_CTRL_DEBOUNCE_EN
    logic [1:0]  deb_lvl_r;
    logic [31:0] deb_cnt_r [2];

    // A new level is accepted only after it has held for DEB_CYCLES consecutive cycles.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl_r    <= 2'b00;
            deb_cnt_r[0] <= 32'd0;
            deb_cnt_r[1] <= 32'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_sync_r[i] == deb_lvl_r[i]) begin
                    deb_cnt_r[i] <= 32'd0;
                end else if (deb_cnt_r[i] >= (DEB_CYCLES - 32'd1)) begin
                    deb_lvl_r[i] <= btn_sync_r[i];
                    deb_cnt_r[i] <= 32'd0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + 32'd1;
                end
            end
        end
    end

    assign btn_lvl_s = deb_lvl_r;
`else
    logic deb_unused_s;
    assign deb_unused_s = (DEB_CYCLES != 32'd0);
    assign btn_lvl_s    = btn_sync_r;
`endif

    // Previous level for rising-edge detection.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_r <= 2'b00;
        end else begin
            btn_prev_r <= btn_lvl_s;
        end
    end

    assign rise_s = btn_lvl_s & ~btn_prev_r;

    // Saturating target index; simultaneous up and down cancel out.
    always_comb begin
        target_s = target_r;
        if (rise_s[0] && !rise_s[1]) begin
            if (target_r != IDX_MAX) begin
                target_s = target_r + 2'd1;
            end else begin
                target_s = target_r;
            end
        end else if (rise_s[1] && !rise_s[0]) begin
            if (target_r != IDX_MIN) begin
                target_s = target_r - 2'd1;
            end else begin
                target_s = target_r;
            end
        end else begin
            target_s = target_r;
        end
    end

    // Commit FSM: selection changes only while idle or on a period boundary.
    always_comb begin
        state_s  = state_r;
        sel_s    = sel_r;
        reload_s = 1'b0;
        case (state_r)
            IDLE: begin
                sel_s = target_r;
                if (run) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!run) begin
                    state_s = IDLE;
                end else if (target_r != sel_r) begin
                    state_s = PEND;
                end else begin
                    state_s = RUN;
                end
            end
            PEND: begin
                if (!run) begin
                    state_s = IDLE;
                end else if (wrap_s) begin
                    sel_s    = target_r;
                    reload_s = 1'b1;
                    state_s  = RUN;
                end else if (target_r == sel_r) begin
                    state_s = RUN;
                end else begin
                    state_s = PEND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            target_r  <= 2'd0;
            sel_r     <= 2'd0;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            target_r  <= target_s;
            sel_r     <= sel_s;
            pending_r <= (target_r != sel_r);
        end
    end

    assign en_s   = run && (state_r != IDLE);
    assign divn_s = preset_for(sel_r, PRESET0, PRESET1, PRESET2, PRESET3);

    prog_fdiv u_fdiv (
        .fin    (fin),
        .rst_n  (rst_n),
        .en     (en_s),
        .reload (reload_s),
        .divn   (divn_s),
        .fout   (fout),
        .tick   (tick),
        .wrap   (wrap_s)
    );

    assign sel     = sel_r;
    assign pending = pending_r;

endmodule
